// File: rtl/ifu_fetch_if.sv
// Handshake bundle between the fetch unit and its neighbours: write-back commit,
// instruction memory and decode.
interface ifu_fetch_if;
    logic        write_back_i_valid;
    logic        write_back_i_need_jump;
    logic [31:0] write_back_i_jump_pc;
    logic        fetch_o_imem_req_valid;
    logic        imem_i_req_ready;
    logic [31:0] fetch_o_imem_addr;
    logic        imem_i_rsp_valid;
    logic [31:0] imem_i_rsp_data;
    logic        imem_i_rsp_err;
    logic        fetch_o_valid;
    logic        decode_i_ready;
    logic [31:0] fetch_o_instr;
    logic [31:0] fetch_o_pc;
    logic        fetch_o_err;

    modport master (
        input  write_back_i_valid, write_back_i_need_jump, write_back_i_jump_pc,
        input  imem_i_req_ready, imem_i_rsp_valid, imem_i_rsp_data, imem_i_rsp_err,
        input  decode_i_ready,
        output fetch_o_imem_req_valid, fetch_o_imem_addr,
        output fetch_o_valid, fetch_o_instr, fetch_o_pc, fetch_o_err
    );

    modport slave (
        output write_back_i_valid, write_back_i_need_jump, write_back_i_jump_pc,
        output imem_i_req_ready, imem_i_rsp_valid, imem_i_rsp_data, imem_i_rsp_err,
        output decode_i_ready,
        input  fetch_o_imem_req_valid, fetch_o_imem_addr,
        input  fetch_o_valid, fetch_o_instr, fetch_o_pc, fetch_o_err
    );
endinterface

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch: one outstanding memory request at a time, next PC
// driven by the write-back commit, sticky error on misalignment, bus error or timeout.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic         clk,
    input logic         rst,
    ifu_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_BOOT  = 3'd0,
        S_IDLE  = 3'd1,
        S_REQ   = 3'd2,
        S_WAIT  = 3'd3,
        S_VALID = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;
    logic [7:0]  cnt_r;
    logic        req_valid_r;
    logic        valid_r;
    logic        err_r;

    logic [31:0] next_pc_s;
    logic        misaligned_s;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    // Candidate PC for a retire seen in S_IDLE; the +4 wraps modulo 2^32
    always_comb begin
        next_pc_s = pc_r + 32'd4;
        if (bus.write_back_i_need_jump) begin
            next_pc_s = bus.write_back_i_jump_pc;
        end else begin
            next_pc_s = pc_r + 32'd4;
        end
        misaligned_s = is_misaligned(next_pc_s);
    end

    // Fetch FSM with all handshake outputs registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_BOOT;
            pc_r        <= RESET_PC;
            instr_r     <= NOP_INSTR;
            cnt_r       <= 8'd0;
            req_valid_r <= 1'b0;
            valid_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                S_BOOT: begin
                    state_r     <= S_REQ;
                    req_valid_r <= 1'b1;
                end
                S_IDLE: begin
                    if (bus.write_back_i_valid) begin
                        pc_r <= next_pc_s;
                        if (misaligned_s) begin
                            state_r <= S_ERR;
                            err_r   <= 1'b1;
                            instr_r <= NOP_INSTR;
                        end else begin
                            state_r     <= S_REQ;
                            req_valid_r <= 1'b1;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (bus.imem_i_req_ready) begin
                        state_r     <= S_WAIT;
                        req_valid_r <= 1'b0;
                        cnt_r       <= 8'd0;
                    end else begin
                        state_r <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_i_rsp_valid && !bus.imem_i_rsp_err) begin
                        state_r <= S_VALID;
                        instr_r <= bus.imem_i_rsp_data;
                        valid_r <= 1'b1;
                    end else if (bus.imem_i_rsp_valid || (cnt_r == TMO_LAST)) begin
                        // Bus error and timeout share the same absorbing error exit
                        state_r <= S_ERR;
                        err_r   <= 1'b1;
                        instr_r <= NOP_INSTR;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                S_VALID: begin
                    if (bus.decode_i_ready) begin
                        state_r <= S_IDLE;
                        valid_r <= 1'b0;
                    end else begin
                        state_r <= S_VALID;
                    end
                end
                S_ERR: begin
                    state_r     <= S_ERR;
                    err_r       <= 1'b1;
                    instr_r     <= NOP_INSTR;
                    req_valid_r <= 1'b0;
                    valid_r     <= 1'b0;
                end
                default: begin
                    // An illegal encoding is treated as a fault, never silently recovered
                    state_r     <= S_ERR;
                    err_r       <= 1'b1;
                    instr_r     <= NOP_INSTR;
                    req_valid_r <= 1'b0;
                    valid_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fetch_o_imem_req_valid = req_valid_r;
    assign bus.fetch_o_imem_addr      = pc_r;
    assign bus.fetch_o_valid          = valid_r;
    assign bus.fetch_o_instr          = instr_r;
    assign bus.fetch_o_pc             = pc_r;
    assign bus.fetch_o_err            = err_r;

endmodule
